max_tree_twos_comp: RTL and testbench
=====================================

MAX_TREE_TWOS_COMP -- requirements
Module: max_tree_twos_comp

Interface
REQ-001 Parameter SIZE, default 8: width of each two's-complement input sample.
REQ-002 Parameter NUM_IN, default 64: number of inputs; power of two, 4..64.
REQ-003 Parameter INDEX_W, default 6: width of index outputs; SHALL hold NUM_IN-1+INDEX_OFFSET.
REQ-004 Parameter INDEX_OFFSET, default 0: constant added to every reported index.
REQ-005 Parameter BEAT_W, default 8: width of the accumulator beat counter.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset_n  in  1  reset, synchronous and active-low.
REQ-008 in_data  in  NUM_IN*SIZE  packed samples; sample k at bits [k*SIZE +: SIZE].
REQ-009 in_valid  in  1  qualifies in_data this cycle.
REQ-010 in_last  in  1  marks final beat of an accumulation frame; ignored unless in_valid.
REQ-011 max_val  out  SIZE  largest sample of the beat.
REQ-012 max_index  out  INDEX_W  position of max_val plus INDEX_OFFSET.
REQ-013 out_valid  out  1  qualifies max_val/max_index for one cycle.
REQ-014 acc_val, acc_index, acc_beat, acc_valid  out  SIZE, INDEX_W, BEAT_W, 1  frame maximum, its in-beat index, its beat number, strobe (present only with MAX_TREE_ACCUM_EN).

Function
REQ-015 Comparison SHALL be signed two's complement over the full SIZE bits (0x80 < 0xFF < 0x00 < 0x7F for SIZE=8).
REQ-016 On equal values the lower input index SHALL win, at every tree level.
REQ-017 Reduction SHALL be a radix-2 tree of log2(NUM_IN) levels, each level registered; latency in_valid->out_valid = log2(NUM_IN) cycles exactly.
REQ-018 Valid SHALL propagate through a shift pipeline alongside data; throughput one beat per cycle, no back-pressure, no bubbles inserted.
REQ-019 Pipeline stage contents with valid low SHALL not be reported; out_valid low forces no requirement on max_val/max_index other than holding last value.
REQ-020 max_index SHALL be computed as local index + INDEX_OFFSET modulo 2^INDEX_W.
REQ-021 in_last SHALL be carried through the pipeline with its beat.

Reset
REQ-022 While reset_n low at a clock edge: all valid pipeline bits, out_valid, acc_valid cleared; max_val, max_index, acc_val, acc_index, acc_beat set 0; beat counter 0; accumulator empty.
REQ-023 Beats in flight when reset asserts SHALL be discarded; first out_valid after release is for a beat presented after release.

Configuration
REQ-024 Macro MAX_TREE_ACCUM_EN defined: one extra registered stage tracks running maximum across beats from first beat after reset or after a last beat through the beat tagged in_last.
REQ-025 Accumulator: first beat of a frame loads unconditionally; later beats replace only if strictly greater (earlier beat wins ties); beat counter counts beats in frame from 0, saturating at 2^BEAT_W-1.
REQ-026 acc_valid SHALL pulse one cycle, log2(NUM_IN)+1 cycles after the in_last beat, with acc_val/acc_index/acc_beat of the frame; accumulator and counter re-arm the same cycle.
REQ-027 A single beat with in_last SHALL form a one-beat frame (acc_beat=0).
REQ-028 Macro undefined: acc_* ports and accumulator logic absent; in_last port present and ignored.

Structure
REQ-029 Package max_tree_pkg SHALL hold the signed-compare/tie-break function and the clog2 constant helper.
REQ-030 One sub-module max2_stage (register one compare-select of value, index, valid, last) SHALL be instantiated per tree node.

Verification
REQ-031 NUM_IN=4, SIZE=8, samples {0x05,0x7F,0x80,0x00} -> after 2 cycles max_val=0x7F, max_index=1.
REQ-032 All samples 0xFF (-1), INDEX_OFFSET=3 -> max_val=0xFF, max_index=3 (lowest wins tie).
REQ-033 NUM_IN=64, in_valid high 10 consecutive cycles, max at k=beat -> 10 contiguous out_valid, latency 6, max_index=beat number.
REQ-034 ACCUM: 3-beat frame with maxima 0x10, 0x30, 0x30 (last beat) -> acc_val=0x30, acc_beat=1, single acc_valid at 7 cycles after the last beat (NUM_IN=64).
REQ-035 reset_n low for one cycle while 3 beats in flight -> no out_valid for those beats; new beat after release reports normally.
REQ-036 Random signed vectors vs. reference model over all NUM_IN in {4,8,64}, gaps in in_valid -> values, indices, latency match.

Source files
------------

// File: rtl/max_tree_pkg.sv
// Shared helpers for the signed max-reduction tree: compare/tie-break and clog2.
package max_tree_pkg;

    // Widest sample the compare helper accepts; narrower samples are sign-extended.
    localparam int unsigned CmpW = 64;

    typedef logic signed [CmpW-1:0] cmp_t;

    // True when lhs beats rhs. Ties go to lhs, so callers pass the lower index (or the
    // earlier beat) as lhs.
    function automatic logic lhs_wins(input cmp_t lhs, input cmp_t rhs);
        return lhs >= rhs;
    endfunction

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/max2_stage.sv
// One registered tree node: picks the larger of two signed candidates, carrying index,
// valid and last alongside.
module max2_stage
    import max_tree_pkg::*;
#(
    parameter int unsigned SIZE    = 8,
    parameter int unsigned INDEX_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [SIZE-1:0]    a_val,
    input  logic [INDEX_W-1:0] a_idx,
    input  logic               a_valid,
    input  logic               a_last,
    input  logic [SIZE-1:0]    b_val,
    input  logic [INDEX_W-1:0] b_idx,
    input  logic               b_valid,
    input  logic               b_last,
    output logic [SIZE-1:0]    y_val,
    output logic [INDEX_W-1:0] y_idx,
    output logic               y_valid,
    output logic               y_last
);

    logic a_win;
    logic beat_valid;

    assign a_win      = lhs_wins(cmp_t'(signed'(a_val)), cmp_t'(signed'(b_val)));
    assign beat_valid = a_valid & b_valid;

    // Value/index only move with a valid beat so the root holds its last report.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y_val   <= '0;
            y_idx   <= '0;
            y_valid <= 1'b0;
            y_last  <= 1'b0;
        end else begin
            y_valid <= beat_valid;
            y_last  <= a_last & b_last;
            if (beat_valid) begin
                y_val <= a_win ? a_val : b_val;
                y_idx <= a_win ? a_idx : b_idx;
            end
        end
    end

endmodule

// File: rtl/max_tree_twos_comp.sv
// Pipelined signed max tree over NUM_IN samples, one registered level per log2 step.
// Define MAX_TREE_ACCUM_EN to add a frame-maximum accumulator stage after the root.
module max_tree_twos_comp
    import max_tree_pkg::*;
#(
    parameter int unsigned SIZE         = 8,
    parameter int unsigned NUM_IN       = 64,
    parameter int unsigned INDEX_W      = 6,
    parameter int unsigned INDEX_OFFSET = 0,
    parameter int unsigned BEAT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_IN*SIZE-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic [SIZE-1:0]        max_val,
    output logic [INDEX_W-1:0]     max_index,
    output logic                   out_valid
`ifdef MAX_TREE_ACCUM_EN
    ,
    output logic [SIZE-1:0]        acc_val,
    output logic [INDEX_W-1:0]     acc_index,
    output logic [BEAT_W-1:0]      acc_beat,
    output logic                   acc_valid
`endif
);

    localparam int unsigned Levels = clog2(NUM_IN);
    localparam int unsigned Nodes  = 2 * NUM_IN - 1;

    // Heap-ordered nodes: 0 is the root, children of n are 2n+1 / 2n+2, and leaves
    // NUM_IN-1 .. Nodes-1 hold samples in ascending order, so left always means lower index.
    logic [SIZE-1:0]    node_val   [Nodes];
    logic [INDEX_W-1:0] node_idx   [Nodes];
    logic               node_valid [Nodes];
    logic               node_last  [Nodes];

    for (genvar k = 0; k < NUM_IN; k++) begin : g_leaf
        assign node_val[NUM_IN-1+k]   = in_data[k*SIZE +: SIZE];
        // Offset is folded in at the leaf so reset leaves max_index at zero.
        assign node_idx[NUM_IN-1+k]   = INDEX_W'(k + INDEX_OFFSET);
        assign node_valid[NUM_IN-1+k] = in_valid;
        assign node_last[NUM_IN-1+k]  = in_last;
    end

    for (genvar n = 0; n < NUM_IN - 1; n++) begin : g_node
        max2_stage #(
            .SIZE    (SIZE),
            .INDEX_W (INDEX_W)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .a_val   (node_val[2*n+1]),
            .a_idx   (node_idx[2*n+1]),
            .a_valid (node_valid[2*n+1]),
            .a_last  (node_last[2*n+1]),
            .b_val   (node_val[2*n+2]),
            .b_idx   (node_idx[2*n+2]),
            .b_valid (node_valid[2*n+2]),
            .b_last  (node_last[2*n+2]),
            .y_val   (node_val[n]),
            .y_idx   (node_idx[n]),
            .y_valid (node_valid[n]),
            .y_last  (node_last[n])
        );
    end

    assign max_val   = node_val[0];
    assign max_index = node_idx[0];
    assign out_valid = node_valid[0];

`ifdef MAX_TREE_ACCUM_EN
    localparam logic [BEAT_W-1:0] BeatMax = '1;

    logic [SIZE-1:0]    run_val_q,  run_val_d;
    logic [INDEX_W-1:0] run_idx_q,  run_idx_d;
    logic [BEAT_W-1:0]  run_beat_q, run_beat_d;
    logic               run_have_q, run_have_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [SIZE-1:0]    acc_val_q,  acc_val_d;
    logic [INDEX_W-1:0] acc_idx_q,  acc_idx_d;
    logic [BEAT_W-1:0]  acc_beat_q, acc_beat_d;
    logic               acc_vld_q,  acc_vld_d;
    logic               new_wins;

    // Held running max wins ties, so a later beat must be strictly greater.
    assign new_wins = !run_have_q ||
                      !lhs_wins(cmp_t'(signed'(run_val_q)), cmp_t'(signed'(node_val[0])));

    always_comb begin
        run_val_d  = run_val_q;
        run_idx_d  = run_idx_q;
        run_beat_d = run_beat_q;
        run_have_d = run_have_q;
        beat_cnt_d = beat_cnt_q;
        acc_val_d  = acc_val_q;
        acc_idx_d  = acc_idx_q;
        acc_beat_d = acc_beat_q;
        acc_vld_d  = 1'b0;
        if (node_valid[0]) begin
            if (new_wins) begin
                run_val_d  = node_val[0];
                run_idx_d  = node_idx[0];
                run_beat_d = beat_cnt_q;
            end
            run_have_d = 1'b1;
            beat_cnt_d = (beat_cnt_q == BeatMax) ? beat_cnt_q : beat_cnt_q + BEAT_W'(1);
            if (node_last[0]) begin
                acc_val_d  = run_val_d;
                acc_idx_d  = run_idx_d;
                acc_beat_d = run_beat_d;
                acc_vld_d  = 1'b1;
                run_have_d = 1'b0;
                beat_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_val_q  <= '0;
            run_idx_q  <= '0;
            run_beat_q <= '0;
            run_have_q <= 1'b0;
            beat_cnt_q <= '0;
            acc_val_q  <= '0;
            acc_idx_q  <= '0;
            acc_beat_q <= '0;
            acc_vld_q  <= 1'b0;
        end else begin
            run_val_q  <= run_val_d;
            run_idx_q  <= run_idx_d;
            run_beat_q <= run_beat_d;
            run_have_q <= run_have_d;
            beat_cnt_q <= beat_cnt_d;
            acc_val_q  <= acc_val_d;
            acc_idx_q  <= acc_idx_d;
            acc_beat_q <= acc_beat_d;
            acc_vld_q  <= acc_vld_d;
        end
    end

    assign acc_val   = acc_val_q;
    assign acc_index = acc_idx_q;
    assign acc_beat  = acc_beat_q;
    assign acc_valid = acc_vld_q;
`else
    // Last still rides the pipeline; without the accumulator nothing consumes it.
    logic unused_root_last;
    assign unused_root_last = node_last[0];
`endif

    if (Levels < 2) begin : g_unused_levels
        logic unused_levels;
        assign unused_levels = 1'b0;
    end

endmodule

// File: tb/tb_max_tree_twos_comp.sv
// Bench for max_tree_twos_comp: four configurations checked every cycle against a
// history-based model, plus hand-computed literal checks.
module tb_max_tree_twos_comp;

    localparam int MaxCyc = 2048;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [511:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;

    always #5 clk = ~clk;

    // inst0: N4 off0 W2 | inst1: N4 off3 W3 | inst2: N8 off5 W3 BEAT_W2 | inst3: N64 defaults
    logic [7:0] mv0, mv1, mv2, mv3;
    logic [1:0] mi0;
    logic [2:0] mi1, mi2;
    logic [5:0] mi3;
    logic       ov0, ov1, ov2, ov3;
    logic [7:0] av0, av1, av2, av3;
    logic [1:0] ai0;
    logic [2:0] ai1, ai2;
    logic [5:0] ai3;
    logic [7:0] ab0, ab1, ab3;
    logic [1:0] ab2;
    logic       aval0, aval1, aval2, aval3;

`ifdef MAX_TREE_ACCUM_EN
    max_tree_twos_comp #(.SIZE(8), .NUM_IN(4), .INDEX_W(2), .INDEX_OFFSET(0), .BEAT_W(8)) u4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[31:0]), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv0), .max_index(mi0), .out_valid(ov0),
        .acc_val(av0), .acc_index(ai0), .acc_beat(ab0), .acc_valid(aval0));
    max_tree_twos_comp #(.SIZE(8), .NUM_IN(4), .INDEX_W(3), .INDEX_OFFSET(3), .BEAT_W(8)) u4o (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[31:0]), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv1), .max_index(mi1), .out_valid(ov1),
        .acc_val(av1), .acc_index(ai1), .acc_beat(ab1), .acc_valid(aval1));
    max_tree_twos_comp #(.SIZE(8), .NUM_IN(8), .INDEX_W(3), .INDEX_OFFSET(5), .BEAT_W(2)) u8 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[63:0]), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv2), .max_index(mi2), .out_valid(ov2),
        .acc_val(av2), .acc_index(ai2), .acc_beat(ab2), .acc_valid(aval2));
    max_tree_twos_comp u64 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv3), .max_index(mi3), .out_valid(ov3),
        .acc_val(av3), .acc_index(ai3), .acc_beat(ab3), .acc_valid(aval3));
`else
    max_tree_twos_comp #(.SIZE(8), .NUM_IN(4), .INDEX_W(2), .INDEX_OFFSET(0), .BEAT_W(8)) u4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[31:0]), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv0), .max_index(mi0), .out_valid(ov0));
    max_tree_twos_comp #(.SIZE(8), .NUM_IN(4), .INDEX_W(3), .INDEX_OFFSET(3), .BEAT_W(8)) u4o (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[31:0]), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv1), .max_index(mi1), .out_valid(ov1));
    max_tree_twos_comp #(.SIZE(8), .NUM_IN(8), .INDEX_W(3), .INDEX_OFFSET(5), .BEAT_W(2)) u8 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[63:0]), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv2), .max_index(mi2), .out_valid(ov2));
    max_tree_twos_comp u64 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .max_val(mv3), .max_index(mi3), .out_valid(ov3));
    assign {av0, av1, av2, av3, ai0, ai1, ai2, ai3} = '0;
    assign {ab0, ab1, ab2, ab3, aval0, aval1, aval2, aval3} = '0;
`endif

    int checks = 0;
    int errors = 0;

    // Input history, indexed by clock edge number.
    int           cyc = 0;
    logic         hv [MaxCyc];
    logic         hl [MaxCyc];
    logic         hr [MaxCyc];
    logic [511:0] hd [MaxCyc];

    logic [7:0] hold_v [4];
    int         hold_i [4];
    logic       pev    [4];
    logic       plast  [4];
    logic [7:0] pv     [4];
    int         pi     [4];
    logic [7:0] fqv    [4][$];
    int         fqi    [4][$];
    logic       xav    [4];
    logic [7:0] xa_v   [4];
    int         xa_i   [4];
    int         xa_b   [4];

    task automatic cmp(input int id, input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL inst%0d %s edge %0d: got %0d expected %0d", id, nm, cyc, act, exp);
        end
    endtask

    // First maximum among the lowest n samples of the beat at edge s.
    task automatic beat_max(input int s, input int n, output logic [7:0] bv, output int bp);
        logic [7:0] v;
        bv = hd[s][7:0];
        bp = 0;
        for (int k = 1; k < n; k++) begin
            v = hd[s][k*8 +: 8];
            if ($signed(v) > $signed(bv)) begin
                bv = v;
                bp = k;
            end
        end
    endtask

    task automatic chk(input int id, input int n, input int lv, input int w, input int off,
                       input int bw, input logic ov, input logic [7:0] mv, input int mi,
                       input logic aval, input logic [7:0] av, input int ai, input int ab);
        logic       ev;
        int         s;
        logic [7:0] bv;
        int         bp;
        int         best;
        ev = 1'b0;
        s  = cyc - lv + 1;
        if (s >= 1) begin
            ev = hv[s];
            for (int c = s; c <= cyc; c++) if (!hr[c]) ev = 1'b0;
        end
        if (!hr[cyc]) begin
            hold_v[id] = 8'h00;
            hold_i[id] = 0;
        end else if (ev) begin
            beat_max(s, n, bv, bp);
            hold_v[id] = bv;
            hold_i[id] = (bp + off) % (1 << w);
        end
        cmp(id, "out_valid", int'(ov), int'(ev));
        cmp(id, "max_val", int'(mv), int'(hold_v[id]));
        cmp(id, "max_index", mi, hold_i[id]);
`ifdef MAX_TREE_ACCUM_EN
        xav[id] = 1'b0;
        if (!hr[cyc]) begin
            fqv[id].delete();
            fqi[id].delete();
            xa_v[id] = 8'h00;
            xa_i[id] = 0;
            xa_b[id] = 0;
        end else if (pev[id]) begin
            fqv[id].push_back(pv[id]);
            fqi[id].push_back(pi[id]);
            if (plast[id]) begin
                best = 0;
                for (int j = 1; j < fqv[id].size(); j++)
                    if ($signed(fqv[id][j]) > $signed(fqv[id][best])) best = j;
                xa_v[id] = fqv[id][best];
                xa_i[id] = fqi[id][best];
                xa_b[id] = (best > (1 << bw) - 1) ? (1 << bw) - 1 : best;
                xav[id]  = 1'b1;
                fqv[id].delete();
                fqi[id].delete();
            end
        end
        pev[id]   = ev;
        plast[id] = ev ? hl[s] : 1'b0;
        pv[id]    = hold_v[id];
        pi[id]    = hold_i[id];
        cmp(id, "acc_valid", int'(aval), int'(xav[id]));
        cmp(id, "acc_val", int'(av), int'(xa_v[id]));
        cmp(id, "acc_index", ai, xa_i[id]);
        cmp(id, "acc_beat", ab, xa_b[id]);
`else
        if (aval || (av != 8'h00) || (ai != 0) || (ab != 0) || (bw < 0)) begin
            cmp(id, "acc_tied", 1, 0);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            hold_v[i] = 8'h00; hold_i[i] = 0; pev[i] = 1'b0; plast[i] = 1'b0;
            pv[i] = 8'h00; pi[i] = 0; xav[i] = 1'b0; xa_v[i] = 8'h00; xa_i[i] = 0; xa_b[i] = 0;
        end
        forever begin
            @(posedge clk);
            if (cyc < MaxCyc - 1) begin
                cyc++;
                hv[cyc] = in_valid;
                hl[cyc] = in_last;
                hr[cyc] = reset_n;
                hd[cyc] = in_data;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk(0, 4, 2, 2, 0, 8, ov0, mv0, int'(mi0), aval0, av0, int'(ai0), int'(ab0));
            chk(1, 4, 2, 3, 3, 8, ov1, mv1, int'(mi1), aval1, av1, int'(ai1), int'(ab1));
            chk(2, 8, 3, 3, 5, 2, ov2, mv2, int'(mi2), aval2, av2, int'(ai2), int'(ab2));
            chk(3, 64, 6, 6, 0, 8, ov3, mv3, int'(mi3), aval3, av3, int'(ai3), int'(ab3));
        end
    end

    logic [7:0] smp [64];

    task automatic drive(input logic v, input logic l);
        @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) in_data[k*8 +: 8] = smp[k];
        in_valid = v;
        in_last  = l;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int k = 0; k < 64; k++) smp[k] = v;
    endtask

    int first_t, cnt, last_t, idx_bad, flush_cnt;

    initial begin
        fill(8'h00);
        repeat (3) @(posedge clk);
        #3;
        cmp(-1, "reset_out_valid", int'(ov3), 0);
        cmp(-1, "reset_max_val", int'(mv3), 0);
        cmp(-1, "reset_max_index", int'(mi1), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Signed ordering: 0x7F beats 0x00, 0x05 and 0x80.
        fill(8'h80);
        smp[0] = 8'h05; smp[1] = 8'h7F; smp[2] = 8'h80; smp[3] = 8'h00;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        @(posedge clk);
        #3;
        cmp(-1, "lit_order_valid", int'(ov0), 1);
        cmp(-1, "lit_order_val", int'(mv0), 8'h7F);
        cmp(-1, "lit_order_index", int'(mi0), 1);

        // All -1: lowest index wins, offsets added.
        fill(8'hFF);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        @(posedge clk);
        #3;
        cmp(-1, "lit_tie_val", int'(mv1), 8'hFF);
        cmp(-1, "lit_tie_index", int'(mi1), 3);
        @(posedge clk);
        #3;
        cmp(-1, "lit_tie_wrap_index", int'(mi2), 5);
`ifdef MAX_TREE_ACCUM_EN
        cmp(-1, "lit_onebeat_valid", int'(aval1), 1);
        cmp(-1, "lit_onebeat_beat", int'(ab1), 0);
`endif
        repeat (6) drive(1'b0, 1'b0);

        // Three-beat frame: 0x10, 0x30, 0x30; the earlier 0x30 must win.
        fill(8'h01); smp[7] = 8'h10;
        drive(1'b1, 1'b0);
        fill(8'h01); smp[20] = 8'h30;
        drive(1'b1, 1'b0);
        fill(8'h01); smp[3] = 8'h30;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
`ifdef MAX_TREE_ACCUM_EN
        cmp(-1, "lit_frame_early", int'(aval3), 0);
`endif
        @(posedge clk);
        #3;
`ifdef MAX_TREE_ACCUM_EN
        cmp(-1, "lit_frame_valid", int'(aval3), 1);
        cmp(-1, "lit_frame_val", int'(av3), 8'h30);
        cmp(-1, "lit_frame_index", int'(ai3), 20);
        cmp(-1, "lit_frame_beat", int'(ab3), 1);
`endif
        repeat (4) drive(1'b0, 1'b0);

        // Ten back-to-back beats, max at k == beat number.
        first_t = -1; cnt = 0; last_t = -1; idx_bad = 0;
        fork
            begin
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < 64; k++) smp[k] = 8'(8'h80 + $urandom_range(63));
                    smp[b] = 8'h70;
                    drive(1'b1, b == 9);
                end
                drive(1'b0, 1'b0);
            end
            begin
                for (int t = 1; t <= 30; t++) begin
                    @(posedge clk);
                    #3;
                    if (ov3) begin
                        if (first_t < 0) first_t = t;
                        if (int'(mi3) != cnt) idx_bad++;
                        cnt++;
                        last_t = t;
                    end
                end
            end
        join
        cmp(-1, "lit_burst_latency", first_t, 7);
        cmp(-1, "lit_burst_count", cnt, 10);
        cmp(-1, "lit_burst_contig", last_t - first_t + 1, 10);
        cmp(-1, "lit_burst_index", idx_bad, 0);

        // Reset for one edge with three beats in flight.
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 64; k++) smp[k] = 8'($urandom);
            drive(1'b1, 1'b0);
        end
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        flush_cnt = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            #3;
            if (ov3) flush_cnt++;
        end
        cmp(-1, "lit_flush", flush_cnt, 0);
        fill(8'h90); smp[33] = 8'h12;
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        cmp(-1, "lit_post_reset_valid", int'(ov3), 1);
        cmp(-1, "lit_post_reset_index", int'(mi3), 33);

        // Random beats with gaps and ties.
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(3) == 0) begin
                for (int k = 0; k < 64; k++) begin
                    case ($urandom_range(3))
                        0: smp[k] = 8'h80;
                        1: smp[k] = 8'hFF;
                        2: smp[k] = 8'h00;
                        default: smp[k] = 8'h7F;
                    endcase
                end
            end else begin
                for (int k = 0; k < 64; k++) smp[k] = 8'($urandom);
            end
            drive($urandom_range(9) < 7, $urandom_range(19) < 3);
        end
        repeat (12) drive(1'b0, 1'b0);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
